psg_bus_sequencer: RTL and testbench

Arbitrates YM2149 PSG register access between two requesters: port 0 (main CPU, FD0D/FD0E path) and port 1 (auxiliary master, e.g. a BIOS-less register initializer or save-state restore). It converts each accepted request into the PSG's BDIR/BC1 bus protocol. The protocol is address latch, inactive gap, then write or read, then inactive tail, with every phase timed in PSG clock-enable pulses. The block sits between the sound-port decode logic and `ym2149_audio`, replacing direct CPU drive of BDIR/BC1.

---
 rtl/psg_seq_pkg.sv | 23 ++
 rtl/psg_phase_timer.sv | 35 +++
 rtl/psg_bus_sequencer.sv | 163 ++++++++++++++++
 tb/tb_psg_bus_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/psg_seq_pkg.sv
// Shared types and bus codes for the YM2149 bus sequencer.
// Imported by the sequencer top and its phase timer.
package psg_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_GAP,
      ST_DATA,
      ST_TAIL
   } state_e;

   typedef enum logic {
      OWN_P0 = 1'b0,
      OWN_P1 = 1'b1
   } owner_e;

   localparam logic [1:0] PSG_INACT = 2'b00;
   localparam logic [1:0] PSG_READ  = 2'b01;
   localparam logic [1:0] PSG_WRITE = 2'b10;
   localparam logic [1:0] PSG_LATCH = 2'b11;

endpackage

// File: rtl/psg_phase_timer.sv
// Counts en_psg pulses within one bus phase and strobes phase_done
// on the pulse that completes PHASE_CEN pulses.
module psg_phase_timer #(
   parameter int unsigned PHASE_CEN = 2
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic run_i,
   input  logic en_i,
   output logic done_o
);

   logic [3:0] cnt_q, cnt_d;

   assign done_o = run_i & en_i & (cnt_q == 4'(PHASE_CEN - 1));

   // Idle and every phase boundary restart the count at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (!run_i || done_o) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/psg_bus_sequencer.sv
// Two-port arbiter that turns register requests into YM2149
// BDIR/BC1 latch, gap, data and tail phases.
module psg_bus_sequencer
   import psg_seq_pkg::*;
#(
   parameter int unsigned PHASE_CEN  = 2,
   parameter int unsigned STARVE_MAX = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en_psg,
   input  logic       p0_valid,
   input  logic       p0_we,
   input  logic [3:0] p0_addr,
   input  logic [7:0] p0_wdata,
   output logic       p0_ready,
   output logic       p0_rvalid,
   output logic [7:0] p0_rdata,
   input  logic       p1_valid,
   input  logic       p1_we,
   input  logic [3:0] p1_addr,
   input  logic [7:0] p1_wdata,
   output logic       p1_ready,
   output logic       p1_rvalid,
   output logic [7:0] p1_rdata,
   output logic       psg_bdir,
   output logic       psg_bc1,
   output logic [7:0] psg_dout,
   input  logic [7:0] psg_din,
   output logic       busy
);

   localparam logic [3:0] SMAX = 4'(STARVE_MAX);

   state_e     state_q, state_d;
   owner_e     owner_q, owner_d;
   logic       we_q, we_d;
   logic [3:0] addr_q, addr_d;
   logic [7:0] wdata_q, wdata_d;
   logic [3:0] starve_cnt_q, starve_cnt_d;
   logic [7:0] rd0_q, rd0_d, rd1_q, rd1_d;
   logic       rvalid_q, rvalid_d;
   logic       phase_done;
   logic       pick0, pick1;
   logic [1:0] code;

   psg_phase_timer #(
      .PHASE_CEN(PHASE_CEN)
   ) u_timer (
      .clk_i  (clk),
      .reset_i(reset),
      .run_i  (state_q != ST_IDLE),
      .en_i   (en_psg),
      .done_o (phase_done)
   );

   // Port 1 wins a tie only once port 0 has used its starvation budget.
   assign pick1 = (state_q == ST_IDLE) & p1_valid
                & (!p0_valid | (starve_cnt_q == SMAX));
   assign pick0 = (state_q == ST_IDLE) & p0_valid & !pick1;

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      starve_cnt_d = starve_cnt_q;
      rd0_d        = rd0_q;
      rd1_d        = rd1_q;
      rvalid_d     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (pick1) begin
               state_d      = ST_ADDR;
               owner_d      = OWN_P1;
               we_d         = p1_we;
               addr_d       = p1_addr;
               wdata_d      = p1_wdata;
               starve_cnt_d = '0;
            end else if (pick0) begin
               state_d = ST_ADDR;
               owner_d = OWN_P0;
               we_d    = p0_we;
               addr_d  = p0_addr;
               wdata_d = p0_wdata;
               if (!p1_valid) begin
                  starve_cnt_d = '0;
               end else if (starve_cnt_q != SMAX) begin
                  starve_cnt_d = starve_cnt_q + 4'd1;
               end
            end
         end
         ST_ADDR: if (phase_done) state_d = ST_GAP;
         ST_GAP:  if (phase_done) state_d = ST_DATA;
         ST_DATA: begin
            if (phase_done) begin
               state_d = ST_TAIL;
               if (!we_q) begin
                  rvalid_d = 1'b1;
                  if (owner_q == OWN_P1) rd1_d = psg_din;
                  else                   rd0_d = psg_din;
               end
            end
         end
         ST_TAIL: if (phase_done) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         owner_q      <= OWN_P0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         starve_cnt_q <= '0;
         rd0_q        <= '0;
         rd1_q        <= '0;
         rvalid_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         starve_cnt_q <= starve_cnt_d;
         rd0_q        <= rd0_d;
         rd1_q        <= rd1_d;
         rvalid_q     <= rvalid_d;
      end
   end

   always_comb begin
      code     = PSG_INACT;
      psg_dout = 8'h00;
      unique case (state_q)
         ST_ADDR: begin
            code     = PSG_LATCH;
            psg_dout = {4'h0, addr_q};
         end
         ST_DATA: begin
            code     = we_q ? PSG_WRITE : PSG_READ;
            psg_dout = we_q ? wdata_q : 8'h00;
         end
         default: begin
            code     = PSG_INACT;
            psg_dout = 8'h00;
         end
      endcase
   end

   assign {psg_bdir, psg_bc1} = code;
   assign busy      = (state_q != ST_IDLE);
   assign p0_ready  = pick0 & ~reset;
   assign p1_ready  = pick1 & ~reset;
   assign p0_rvalid = rvalid_q & (owner_q == OWN_P0);
   assign p1_rvalid = rvalid_q & (owner_q == OWN_P1);
   assign p0_rdata  = rd0_q;
   assign p1_rdata  = rd1_q;

endmodule

// File: tb/tb_psg_bus_sequencer.sv
// Directed bench for psg_bus_sequencer: table of transactions plus
// arbitration and back-to-back sequences.
module tb_psg_bus_sequencer;

   localparam int PC = 2;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic       en_psg = 0;
   logic       p0_valid = 0, p1_valid = 0, p0_we = 0, p1_we = 0;
   logic [3:0] p0_addr = 0, p1_addr = 0;
   logic [7:0] p0_wdata = 0, p1_wdata = 0, psg_din = 0;
   logic       p0_ready, p1_ready, p0_rvalid, p1_rvalid;
   logic [7:0] p0_rdata, p1_rdata, psg_dout;
   logic       psg_bdir, psg_bc1, busy;

   logic       q_en = 0, q_valid = 0, q_we = 0;
   logic [3:0] q_addr = 0;
   logic [7:0] q_wdata = 0;
   logic       q_p0_ready, q_p1_ready, q_p0_rvalid, q_p1_rvalid;
   logic [7:0] q_p0_rdata, q_p1_rdata, q_dout;
   logic       q_bdir, q_bc1, q_busy;

   psg_bus_sequencer #(.PHASE_CEN(PC), .STARVE_MAX(2)) dut (
      .clk(clk), .reset(reset), .en_psg(en_psg),
      .p0_valid(p0_valid), .p0_we(p0_we), .p0_addr(p0_addr),
      .p0_wdata(p0_wdata), .p0_ready(p0_ready),
      .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
      .p1_valid(p1_valid), .p1_we(p1_we), .p1_addr(p1_addr),
      .p1_wdata(p1_wdata), .p1_ready(p1_ready),
      .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
      .psg_bdir(psg_bdir), .psg_bc1(psg_bc1), .psg_dout(psg_dout),
      .psg_din(psg_din), .busy(busy)
   );

   psg_bus_sequencer #(.PHASE_CEN(1), .STARVE_MAX(2)) dut1 (
      .clk(clk), .reset(reset), .en_psg(q_en),
      .p0_valid(q_valid), .p0_we(q_we), .p0_addr(q_addr),
      .p0_wdata(q_wdata), .p0_ready(q_p0_ready),
      .p0_rvalid(q_p0_rvalid), .p0_rdata(q_p0_rdata),
      .p1_valid(1'b0), .p1_we(1'b0), .p1_addr(4'h0),
      .p1_wdata(8'h00), .p1_ready(q_p1_ready),
      .p1_rvalid(q_p1_rvalid), .p1_rdata(q_p1_rdata),
      .psg_bdir(q_bdir), .psg_bc1(q_bc1), .psg_dout(q_dout),
      .psg_din(8'h5A), .busy(q_busy)
   );

   typedef struct {
      bit         port;
      bit         we;
      logic [3:0] addr;
      logic [7:0] wdata;
      logic [7:0] din;
      int         stall_p;
      int         rst_p;
   } tr_t;

   tr_t tab[6];
   int n_chk = 0, n_pass = 0;
   int cyc = 0, en_mode = 0, stall_left = 0;
   logic [7:0] m_rd0 = 0, m_rd1 = 0;

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
      cyc++;
      if (stall_left > 0) begin
         en_psg = 1'b0;
         stall_left--;
      end else begin
         en_psg = (en_mode == 1) || (cyc % 4 == 0);
      end
   endtask

   function automatic logic [1:0] code_of(int ph, bit we);
      if (ph == 0) return 2'b11;
      if (ph == 2) return we ? 2'b10 : 2'b01;
      return 2'b00;
   endfunction

   function automatic logic [7:0] dout_of(int ph, tr_t t);
      if (ph == 0) return {4'h0, t.addr};
      if (ph == 2 && t.we) return t.wdata;
      return 8'h00;
   endfunction

   task automatic run_tr(input tr_t t, input int idx);
      int p, ph, k;
      bit rv_exp, stalled;
      if (t.port) begin
         p1_valid = 1; p1_we = t.we; p1_addr = t.addr; p1_wdata = t.wdata;
      end else begin
         p0_valid = 1; p0_we = t.we; p0_addr = t.addr; p0_wdata = t.wdata;
      end
      for (k = 0; k < 50; k++) begin
         #1;
         if (t.port ? p1_ready : p0_ready) break;
         next_cycle();
      end
      chk($sformatf("tr%0d ready", idx), 32'(k < 50), 1);
      chk($sformatf("tr%0d other_ready", idx),
          32'(t.port ? p0_ready : p1_ready), 0);
      next_cycle();
      p0_valid = 0; p1_valid = 0;
      p0_we = ~t.we; p1_we = ~t.we;
      p0_addr = ~t.addr; p1_addr = ~t.addr;
      p0_wdata = ~t.wdata; p1_wdata = ~t.wdata;
      p = 0; rv_exp = 0; stalled = 0;
      for (k = 0; k < 400; k++) begin
         ph = p / PC;
         psg_din = (ph == 2) ? t.din : 8'hEE;
         if (t.stall_p >= 0 && !stalled && p == t.stall_p) begin
            stalled = 1;
            stall_left = 20;
         end
         #1;
         if (t.rst_p >= 0 && p == t.rst_p) begin
            reset = 1;
            #1;
            chk($sformatf("tr%0d rst_bus", idx),
                {psg_bdir, psg_bc1, psg_dout, busy}, 0);
            chk($sformatf("tr%0d rst_rv", idx),
                {p0_rvalid, p1_rvalid, p0_ready, p1_ready}, 0);
            chk($sformatf("tr%0d rst_rdata", idx), {p0_rdata, p1_rdata}, 0);
            m_rd0 = 0; m_rd1 = 0;
            next_cycle();
            next_cycle();
            reset = 0;
            for (int j = 0; j < 40; j++) begin
               next_cycle();
               #1;
               chk($sformatf("tr%0d post_rst c%0d", idx, j),
                   {busy, p0_rvalid, p1_rvalid, psg_bdir, psg_bc1}, 0);
            end
            return;
         end
         chk($sformatf("tr%0d bus p%0d", idx, p),
             {psg_bdir, psg_bc1, psg_dout},
             {code_of(ph, t.we), dout_of(ph, t)});
         chk($sformatf("tr%0d busy p%0d", idx, p), 32'(busy), 32'(ph < 4));
         chk($sformatf("tr%0d rvalid p%0d", idx, p),
             {p0_rvalid, p1_rvalid},
             rv_exp ? (t.port ? 2'b01 : 2'b10) : 2'b00);
         if (ph == 4) break;
         rv_exp = 0;
         if (en_psg) begin
            p++;
            if (!t.we && p == 3 * PC) rv_exp = 1;
         end
         next_cycle();
      end
      chk($sformatf("tr%0d done", idx), 32'(k < 400), 1);
      if (!t.we) begin
         if (t.port) m_rd1 = t.din;
         else        m_rd0 = t.din;
      end
      chk($sformatf("tr%0d rdata", idx), {p0_rdata, p1_rdata}, {m_rd0, m_rd1});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      bit exp_g[6];
      int k;
      logic [1:0] prev, cur;
      logic [9:0] exp_bus;

      tab[0] = '{port:0, we:1, addr:4'h7, wdata:8'h38, din:8'h00,
                 stall_p:-1, rst_p:-1};
      tab[1] = '{port:1, we:0, addr:4'h0, wdata:8'h00, din:8'hA5,
                 stall_p:-1, rst_p:-1};
      tab[2] = '{port:0, we:1, addr:4'h2, wdata:8'h55, din:8'h00,
                 stall_p:3, rst_p:-1};
      tab[3] = '{port:1, we:0, addr:4'h9, wdata:8'h00, din:8'h3C,
                 stall_p:-1, rst_p:5};
      tab[4] = '{port:0, we:0, addr:4'hF, wdata:8'h00, din:8'hC3,
                 stall_p:-1, rst_p:-1};
      tab[5] = '{port:1, we:1, addr:4'h5, wdata:8'h81, din:8'h00,
                 stall_p:-1, rst_p:-1};
      exp_g = '{0, 0, 1, 0, 0, 1};

      reset = 1;
      repeat (3) next_cycle();
      chk("rst bus", {psg_bdir, psg_bc1, psg_dout, busy}, 0);
      chk("rst rv", {p0_rvalid, p1_rvalid, p0_ready, p1_ready}, 0);
      chk("rst rdata", {p0_rdata, p1_rdata}, 0);
      chk("rst q_bus", {q_bdir, q_bc1, q_dout, q_busy}, 0);
      chk("rst q_rv", {q_p0_rvalid, q_p1_rvalid, q_p0_ready, q_p1_ready}, 0);
      chk("rst q_rdata", {q_p0_rdata, q_p1_rdata}, 0);
      reset = 0;
      next_cycle();

      for (int i = 0; i < 6; i++) run_tr(tab[i], i);

      en_mode = 1;
      p0_we = 1; p0_addr = 4'h1; p0_wdata = 8'h11; p0_valid = 1;
      p1_we = 1; p1_addr = 4'h2; p1_wdata = 8'h22; p1_valid = 1;
      for (int g = 0; g < 6; g++) begin
         for (k = 0; k < 100; k++) begin
            #1;
            if (p0_ready || p1_ready) break;
            next_cycle();
         end
         chk($sformatf("arb grant%0d", g), {p0_ready, p1_ready},
             exp_g[g] ? 2'b01 : 2'b10);
         next_cycle();
      end
      p0_valid = 0; p1_valid = 0;
      for (k = 0; k < 100; k++) begin
         #1;
         if (!busy) break;
         next_cycle();
      end
      chk("arb drain", 32'(busy), 0);

      q_en = 1; q_we = 1; q_addr = 4'h4; q_wdata = 8'h9C; q_valid = 1;
      prev = 2'b00;
      for (int c = 0; c <= 10; c++) begin
         if (c == 6) q_valid = 0;
         #1;
         cur = {q_bdir, q_bc1};
         chk($sformatf("b2b ready c%0d", c), 32'(q_p0_ready),
             32'(c == 0 || c == 5));
         case (c % 5)
            1:       exp_bus = {2'b11, 8'h04};
            3:       exp_bus = {2'b10, 8'h9C};
            default: exp_bus = {2'b00, 8'h00};
         endcase
         if (c == 10) exp_bus = 10'h000;
         chk($sformatf("b2b bus c%0d", c), {cur, q_dout}, exp_bus);
         chk($sformatf("b2b adj c%0d", c),
             32'(prev == 2'b11 && (cur == 2'b10 || cur == 2'b01)), 0);
         prev = cur;
         next_cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
